// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-transaction AXI burst slave backed by on-chip block RAM
module axi_sram_slave #(
    parameter int AWIDTH = 12,
    parameter int BEATS  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [5:0]  awatop,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    output logic        bvalid,
    input  logic        bready,
    output logic [3:0]  bid,
    output logic        bcomp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic        rlast
);
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, WDATA, WRESP, RFETCH, RDATA} state_t;

    state_t            state_q, state_d;
    logic [3:0]        id_q, id_d;
    logic [AWIDTH-1:0] addr_q, addr_d, addr_inc;
    logic [BW-1:0]     beat_q, beat_d;
    logic              err_q, err_d;
    logic              awready_q, awready_d;
    logic              arready_q, arready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic              bcomp_q, bcomp_d;
    logic              rvalid_q, rvalid_d;
    logic              rlast_q, rlast_d;
    logic              we, re, aw_hs, ar_hs;
    logic [31:0]       ram_q;
    logic [31:0]       mem [2**AWIDTH];

    // Beats wrap inside the 16-byte line: only the two low word-address bits advance
    assign addr_inc = {addr_q[AWIDTH-1:2], addr_q[1:0] + 2'd1};
    assign aw_hs    = awvalid && awready_q;
    assign ar_hs    = arvalid && arready;

    assign awready = awready_q;
    assign arready = arready_q && !awvalid;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bcomp   = bcomp_q;
    assign bid     = id_q;
    assign rvalid  = rvalid_q;
    assign rid     = id_q;
    assign rlast   = rlast_q;
    assign rdata   = rvalid_q && !err_q ? ram_q : 32'h0;

    // Transaction sequencing: address capture, beat stepping and RAM port enables
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        err_d   = err_q;
        we      = 1'b0;
        re      = 1'b0;
        case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    id_d    = awid;
                    addr_d  = awaddr[AWIDTH+1:2];
                    err_d   = (awaddr >> (AWIDTH + 2)) != 32'h0 || awatop != 6'h0;
                    state_d = WDATA;
                end else if (ar_hs) begin
                    id_d    = arid;
                    addr_d  = araddr[AWIDTH+1:2];
                    beat_d  = '0;
                    err_d   = (araddr >> (AWIDTH + 2)) != 32'h0;
                    state_d = RFETCH;
                end
            end
            WDATA: begin
                if (wvalid) begin
                    we      = !err_q;
                    addr_d  = addr_inc;
                    state_d = wlast ? WRESP : WDATA;
                end
            end
            WRESP: state_d = bready ? IDLE : WRESP;
            RFETCH: begin
                re      = 1'b1;
                addr_d  = addr_inc;
                state_d = RDATA;
            end
            RDATA: begin
                if (rready && beat_q == LAST) begin
                    state_d = IDLE;
                end else if (rready) begin
                    re     = 1'b1;
                    addr_d = addr_inc;
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are decoded from the next state so each port is a flop
    always_comb begin
        awready_d = state_d == IDLE;
        arready_d = state_d == IDLE;
        wready_d  = state_d == WDATA;
        bvalid_d  = state_d == WRESP;
        bcomp_d   = state_d == WRESP && !err_d;
        rvalid_d  = state_d == RDATA;
        rlast_d   = state_d == RDATA && beat_d == LAST;
    end

    // Control state; reset aborts any transaction without issuing a response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            id_q      <= 4'h0;
            addr_q    <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bcomp_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            awready_q <= awready_d;
            arready_q <= arready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bcomp_q   <= bcomp_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
        end
    end

    // Block RAM: byte-masked write port and registered read, contents kept across reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (we && wstrb[b]) mem[addr_q][8*b +: 8] <= wdata[8*b +: 8];
        if (re) ram_q <= mem[addr_q];
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed, table-driven checks of the AXI SRAM slave
module tb_axi_sram_slave;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        awvalid, awready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [5:0]  awatop;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid, bready;
    logic [3:0]  bid;
    logic        bcomp;
    logic        arvalid, arready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic        rvalid, rready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast;
    logic [46:0] outs;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] wd [4];
    logic [3:0]  ws [4];
    logic [31:0] rd [4];
    logic [3:0]  got_bid;
    logic        got_bcomp;

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdat;
        logic [3:0]  strb;
        logic [5:0]  atop;
        logic        exp_bcomp;
        logic [31:0] raddr;
        logic [31:0] exp_r0;
    } vec_t;
    vec_t tbl [8];

    axi_sram_slave #(.AWIDTH(12), .BEATS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awatop(awatop),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bcomp(bcomp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rlast(rlast)
    );

    assign outs = {awready, arready, wready, bvalid, bcomp, bid, rvalid, rlast, rid, rdata};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [5:0] atop,
                            input int n, output logic [3:0] bid_o, output logic bcomp_o);
        int t;
        awvalid = 1'b1;
        awid    = id;
        awaddr  = addr;
        awatop  = atop;
        t = 0;
        while (!awready && t < 20) begin
            tick();
            t++;
        end
        chk("awready", awready, 1);
        tick();
        awvalid = 1'b0;
        chk("wready_t1", wready, 1);
        chk("arready_busy", arready, 0);
        for (int i = 0; i < n; i++) begin
            wvalid = 1'b1;
            wdata  = wd[i];
            wstrb  = ws[i];
            wlast  = i == n - 1;
            chk("wready_beat", wready, 1);
            tick();
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        chk("bvalid_w1", bvalid, 1);
        bid_o   = bid;
        bcomp_o = bcomp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("b_done", bvalid, 0);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input bit bp);
        int t, beats, cyc;
        logic [31:0] snap_d;
        logic        snap_l;
        arvalid = 1'b1;
        arid    = id;
        araddr  = addr;
        t = 0;
        while (!arready && t < 20) begin
            tick();
            t++;
        end
        chk("arready", arready, 1);
        tick();
        arvalid = 1'b0;
        chk("rfetch_quiet", rvalid, 0);
        tick();
        chk("rvalid_t2", rvalid, 1);
        chk("rid", rid, id);
        beats = 0;
        cyc   = 0;
        while (beats < 4 && cyc < 40) begin
            rready = bp ? (cyc % 3 == 0) : 1'b1;
            chk("rvalid_hold", rvalid, 1);
            if (rready) begin
                rd[beats] = rdata;
                chk("rlast", rlast, beats == 3);
                beats++;
                tick();
            end else begin
                snap_d = rdata;
                snap_l = rlast;
                tick();
                chk("stall_rdata", rdata, snap_d);
                chk("stall_rlast", rlast, snap_l);
            end
            cyc++;
        end
        rready = 1'b0;
        chk("r_beats", beats, 4);
        chk("r_done", rvalid, 0);
        if (!bp) chk("r_cycles", cyc, 4);
    endtask

    initial begin
        tbl[0] = '{32'h100,  32'h44332211, 4'hF, 6'h00, 1'b1, 32'h100,  32'h44332211};
        tbl[1] = '{32'h100,  32'hAABBCCDD, 4'h5, 6'h00, 1'b1, 32'h100,  32'h44BB22DD};
        tbl[2] = '{32'h000,  32'h12345678, 4'hF, 6'h00, 1'b1, 32'h000,  32'h12345678};
        tbl[3] = '{32'h4000, 32'hDEADBEEF, 4'hF, 6'h00, 1'b0, 32'h000,  32'h12345678};
        tbl[4] = '{32'h000,  32'h99999999, 4'hF, 6'h01, 1'b0, 32'h000,  32'h12345678};
        tbl[5] = '{32'h200,  32'hCAFEF00D, 4'hF, 6'h00, 1'b1, 32'h4200, 32'h00000000};
        tbl[6] = '{32'h200,  32'h11223344, 4'h8, 6'h00, 1'b1, 32'h200,  32'h11FEF00D};
        tbl[7] = '{32'h3FFC, 32'h0BADF00D, 4'hF, 6'h00, 1'b1, 32'h3FFC, 32'h0BADF00D};

        rst_n = 1'b0;
        {awvalid, wvalid, bready, arvalid, rready, wlast} = '0;
        awid = 4'h0; awaddr = 32'h0; awatop = 6'h0;
        wdata = 32'h0; wstrb = 4'h0; arid = 4'h0; araddr = 32'h0;
        repeat (3) tick();
        chk("reset_outs", outs, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_awready", awready, 1);
        chk("idle_arready", arready, 1);

        wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; wd[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        do_write(4'd3, 32'h100, 6'h0, 4, got_bid, got_bcomp);
        chk("burst_bid", got_bid, 3);
        chk("burst_bcomp", got_bcomp, 1);
        do_read(4'd5, 32'h100, 1'b0);
        for (int i = 0; i < 4; i++) chk("burst_rdata", rd[i], wd[i]);
        do_read(4'd6, 32'h108, 1'b0);
        for (int i = 0; i < 4; i++) chk("wrap_rdata", rd[i], wd[(i + 2) % 4]);
        do_read(4'd7, 32'h100, 1'b1);
        for (int i = 0; i < 4; i++) chk("bp_rdata", rd[i], wd[i]);

        for (int i = 0; i < 8; i++) begin
            wd[0] = tbl[i].wdat;
            ws[0] = tbl[i].strb;
            do_write(4'(i), tbl[i].waddr, tbl[i].atop, 1, got_bid, got_bcomp);
            chk("vec_bid", got_bid, 4'(i));
            chk("vec_bcomp", got_bcomp, tbl[i].exp_bcomp);
            do_read(4'(i + 8), tbl[i].raddr, 1'b0);
            chk("vec_rdata", rd[0], tbl[i].exp_r0);
        end

        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'h30000000 + 32'(i);
            ws[i] = 4'hF;
        end
        awvalid = 1'b1; awid = 4'd1; awaddr = 32'h300; awatop = 6'h0;
        arvalid = 1'b1; arid = 4'd2; araddr = 32'h300;
        #1;
        chk("both_awready", awready, 1);
        chk("both_arready", arready, 0);
        do_write(4'd1, 32'h300, 6'h0, 4, got_bid, got_bcomp);
        chk("both_bcomp", got_bcomp, 1);
        do_read(4'd2, 32'h300, 1'b0);
        for (int i = 0; i < 4; i++) chk("both_rdata", rd[i], wd[i]);

        for (int i = 0; i < 4; i++) wd[i] = 32'hA0000000 + 32'(i);
        do_write(4'd8, 32'h400, 6'h0, 4, got_bid, got_bcomp);
        awvalid = 1'b1; awid = 4'd9; awaddr = 32'h400; awatop = 6'h0;
        tick();
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = 32'hB1B1B1B1; wstrb = 4'hF; wlast = 1'b0;
        tick();
        wdata = 32'hB2B2B2B2;
        rst_n = 1'b0;
        tick();
        chk("midreset_outs", outs, 0);
        wvalid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midreset_no_b", bvalid, 0);
        end
        do_read(4'd10, 32'h400, 1'b0);
        chk("midreset_beat1", rd[0], 32'hB1B1B1B1);
        chk("midreset_beat2", rd[1], 32'hB2B2B2B2);
        chk("midreset_old3", rd[2], 32'hA0000002);
        chk("midreset_old4", rd[3], 32'hA0000003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
